// File: rtl/fn_scan_ctrl.sv
// Truth-table scanner: steps vec through all 2^N_IN codes, waits SETTLE cycles, captures f.
// Optional 16-bit MISR over the captured words when FN_SCAN_MISR_EN is defined.
module fn_scan_ctrl #(
   parameter int N_IN   = 5,
   parameter int N_OUT  = 4,
   parameter int SETTLE = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   output logic [N_IN-1:0]  vec,
   input  logic [N_OUT-1:0] f,
   output logic             busy,
   output logic             done,
   output logic             valid,
   input  logic [N_IN-1:0]  rd_addr,
   output logic [N_OUT-1:0] rd_data,
   output logic [15:0]      sig
);

   localparam int              DEPTH     = 1 << N_IN;
   localparam logic [N_IN-1:0] LAST_VEC  = '1;
   localparam logic [3:0]      WAIT_LAST = 4'(SETTLE - 1);

   typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

   state_t            state_reg, state_next;
   logic [N_IN-1:0]   vec_reg, vec_next;
   logic [3:0]        wait_reg, wait_next;
   logic              valid_reg, valid_next;
   logic              mem_we;
   logic [N_OUT-1:0]  mem [DEPTH];

   // An abort landing on the SAMPLE edge suppresses the capture.
   assign mem_we = (state_reg == SAMPLE) && !abort;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         vec_reg   <= '0;
         wait_reg  <= '0;
         valid_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         vec_reg   <= vec_next;
         wait_reg  <= wait_next;
         valid_reg <= valid_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      vec_next   = vec_reg;
      wait_next  = wait_reg;
      valid_next = valid_reg;
      if (abort && state_reg != IDLE) begin
         state_next = IDLE;
         vec_next   = '0;
         wait_next  = '0;
         valid_next = 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start && !abort) begin
                  state_next = DRIVE;
                  vec_next   = '0;
                  wait_next  = '0;
                  valid_next = 1'b0;
               end
            end
            DRIVE: begin
               wait_next = wait_reg + 4'd1;
               if (wait_reg == WAIT_LAST) state_next = SAMPLE;
            end
            SAMPLE: begin
               wait_next = '0;
               if (vec_reg == LAST_VEC) begin
                  state_next = DONE;
                  vec_next   = '0;
                  valid_next = 1'b1;
               end else begin
                  state_next = DRIVE;
                  vec_next   = vec_reg + N_IN'(1);
               end
            end
            DONE: begin
               state_next = IDLE;
               vec_next   = '0;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // Table store has no reset so it maps onto block RAM; read is registered.
   always_ff @(posedge clk) begin
      if (mem_we) mem[vec_reg] <= f;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rd_data <= '0;
      else     rd_data <= mem[rd_addr];
   end

`ifdef FN_SCAN_MISR_EN
   logic        seed;
   logic [15:0] sig_reg, sig_next;

   assign seed = (state_reg == IDLE) && start && !abort;

   always_comb begin
      sig_next = sig_reg;
      if (seed)
         sig_next = 16'hFFFF;
      else if (mem_we)
         sig_next = {sig_reg[14:0], 1'b0} ^ (sig_reg[15] ? 16'h1021 : 16'h0000)
                    ^ {{(16-N_OUT){1'b0}}, f};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sig_reg <= 16'hFFFF;
      else     sig_reg <= sig_next;
   end

   assign sig = sig_reg;
`else
   assign sig = 16'h0000;
`endif

   assign vec   = vec_reg;
   assign valid = valid_reg;
   assign busy  = (state_reg == DRIVE) || (state_reg == SAMPLE);
   assign done  = (state_reg == DONE);

endmodule

// File: tb/tb_fn_scan_ctrl.sv
// Self-checking bench for fn_scan_ctrl: table vectors, random function tables, abort/reset corners.
// A second instance with SETTLE=1 shows the stale captures of a too-short settle time.
module tb_fn_scan_ctrl;

   localparam int N_IN  = 5;
   localparam int N_OUT = 4;
   localparam int DEPTH = 32;
   localparam int STEP  = 3;            // SETTLE+1 cycles per vector
   localparam int SCAN_EDGES = DEPTH * STEP;
`ifdef FN_SCAN_MISR_EN
   localparam logic [15:0] SIG_RST = 16'hFFFF;
`else
   localparam logic [15:0] SIG_RST = 16'h0000;
`endif

   logic             clk, rst, start, abort;
   logic [N_IN-1:0]  rd_addr;
   logic [N_IN-1:0]  vec, vec1;
   logic [N_OUT-1:0] f, f1, rd_data, rd_data1;
   logic             busy, done, valid, busy1, done1, valid1;
   logic [15:0]      sig, sig1;

   logic [3:0]       ftab    [DEPTH];
   logic [3:0]       exp_tab [DEPTH];
   logic [3:0]       exp1    [DEPTH];
   logic [3:0]       mtab    [DEPTH];
   logic [N_IN-1:0]  vd1, vd2, v1d1, v1d2;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [4:0] addr;
      logic [3:0] data;
   } rd_vec_t;
   rd_vec_t tv [8];

   fn_scan_ctrl #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE(2)) u_dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .vec(vec), .f(f),
      .busy(busy), .done(done), .valid(valid), .rd_addr(rd_addr),
      .rd_data(rd_data), .sig(sig));

   fn_scan_ctrl #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .vec(vec1), .f(f1),
      .busy(busy1), .done(done1), .valid(valid1), .rd_addr(rd_addr),
      .rd_data(rd_data1), .sig(sig1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Function unit model: responds to vec two clocks late.
   always @(posedge clk) begin
      vd1  <= vec;
      vd2  <= vd1;
      v1d1 <= vec1;
      v1d2 <= v1d1;
   end
   assign f  = ftab[vd2];
   assign f1 = ftab[v1d2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   function automatic logic [15:0] misr_model();
      logic [15:0] s;
      s = 16'hFFFF;
      for (int v = 0; v < DEPTH; v++)
         s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {12'h000, mtab[v]};
`ifdef FN_SCAN_MISR_EN
      return s;
`else
      return (s == s) ? 16'h0000 : 16'h0000;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic start_pulse();
      @(negedge clk);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Full scan: returns edges from start edge to done, and busy cycles seen.
   task automatic run_scan(input int restart_at, output int edges, output int busy_cnt);
      start_pulse();
      edges = 0;
      busy_cnt = 0;
      while (done !== 1'b1 && edges < 400) begin
         if (busy) busy_cnt++;
         if (edges < SCAN_EDGES) check("vec_seq", 32'(vec), 32'(edges / STEP));
         start = (edges == restart_at);
         tick();
         start = 1'b0;
         edges++;
      end
      check("done_edges", 32'(edges), 32'(SCAN_EDGES));
      check("busy_cycles", 32'(busy_cnt), 32'(SCAN_EDGES));
      check("busy_in_done", 32'(busy), 32'd0);
      check("valid_in_done", 32'(valid), 32'd1);
      tick();
      check("done_pulse_end", 32'(done), 32'd0);
      check("vec_after_done", 32'(vec), 32'd0);
      check("valid_kept", 32'(valid), 32'd1);
      $display("scan: done after %0d edges, busy %0d cycles", edges, busy_cnt);
   endtask

   task automatic read_all(input string name);
      for (int a = 0; a < DEPTH; a++) begin
         rd_addr = 5'(a);
         tick();
         check(name, 32'(rd_data), 32'(exp_tab[a]));
      end
      $display("readback %s: 32 words compared", name);
   endtask

   task automatic randomize_ftab();
      for (int a = 0; a < DEPTH; a++) ftab[a] = 4'($urandom_range(0, 15));
   endtask

   task automatic abort_test(input int n);
      int done_seen;
      for (int a = 0; a < DEPTH; a++) mtab[a] = exp_tab[a];
      randomize_ftab();
      start_pulse();
      for (int i = 0; i < n; i++) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_vec", 32'(vec), 32'd0);
      check("abort_valid", 32'(valid), 32'd0);
      done_seen = 0;
      for (int i = 0; i < 6; i++) begin
         if (done) done_seen++;
         tick();
      end
      check("abort_no_done", 32'(done_seen), 32'd0);
      for (int k = 0; k < DEPTH; k++)
         exp_tab[k] = (STEP * (k + 1) <= n) ? ftab[k] : mtab[k];
      $display("abort after %0d edges", n);
      read_all("tbl_abort");
   endtask

   initial begin
      int edges, busy_cnt, mism_act, mism_mod, n;
      logic [15:0] f2_mask;

      f2_mask = 16'h6EAD;        // minterms 0,2,3,5,7,9,10,11,13,14 of A..D
      tv[0] = '{5'd0,  4'b0100};
      tv[1] = '{5'd2,  4'b0000};
      tv[2] = '{5'd4,  4'b0100};
      tv[3] = '{5'd6,  4'b0100};
      tv[4] = '{5'd8,  4'b0000};
      tv[5] = '{5'd18, 4'b0100};
      tv[6] = '{5'd28, 4'b0100};
      tv[7] = '{5'd30, 4'b0000};

      rst = 1'b1; start = 1'b0; abort = 1'b0; rd_addr = '0;
      for (int a = 0; a < DEPTH; a++) ftab[a] = f2_mask[a >> 1] ? 4'b0100 : 4'b0000;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_vec", 32'(vec), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_rd_data", 32'(rd_data), 32'd0);
      check("rst_sig", 32'(sig), 32'(SIG_RST));

      // F2 scan with a mid-scan start at cycle 10 that must be ignored
      run_scan(10, edges, busy_cnt);
      for (int i = 0; i < 8; i++) begin
         rd_addr = tv[i].addr;
         tick();
         check("f2_vector", 32'(rd_data), 32'(tv[i].data));
      end
      for (int a = 0; a < DEPTH; a++) begin
         exp_tab[a] = ftab[a];
         mtab[a]    = ftab[a];
      end
      check("sig_f2", 32'(sig), 32'(misr_model()));
      read_all("tbl_f2");

      // SETTLE=1 instance captures the previous vector's response
      mism_act = 0;
      mism_mod = 0;
      for (int k = 0; k < DEPTH; k++) begin
         exp1[k] = ftab[(k == 0) ? 0 : k - 1];
         if (exp1[k] != ftab[k]) mism_mod++;
      end
      for (int a = 0; a < DEPTH; a++) begin
         rd_addr = 5'(a);
         tick();
         check("settle1_word", 32'(rd_data1), 32'(exp1[a]));
         if (rd_data1 != ftab[a]) mism_act++;
      end
      check("settle1_mismatches", 32'(mism_act), 32'(mism_mod));
      check("settle1_valid", 32'(valid1), 32'd1);
      check("settle1_idle", 32'({busy1, done1}), 32'd0);
      for (int a = 0; a < DEPTH; a++) mtab[a] = exp1[a];
      check("settle1_sig", 32'(sig1), 32'(misr_model()));
      $display("settle=1: %0d stale words", mism_act);

      // start and abort together in IDLE: no scan, valid kept
      @(negedge clk);
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      check("start_abort_busy", 32'(busy), 32'd0);
      check("start_abort_valid", 32'(valid), 32'd1);

      // random tables
      for (int r = 0; r < 2; r++) begin
         randomize_ftab();
         run_scan(-1, edges, busy_cnt);
         for (int a = 0; a < DEPTH; a++) begin
            exp_tab[a] = ftab[a];
            mtab[a]    = ftab[a];
         end
         check("sig_rand", 32'(sig), 32'(misr_model()));
         read_all("tbl_rand");
      end

      // f held at zero
      for (int a = 0; a < DEPTH; a++) begin
         ftab[a] = 4'h0;
         mtab[a] = 4'h0;
         exp_tab[a] = 4'h0;
      end
      run_scan(-1, edges, busy_cnt);
      check("sig_zero", 32'(sig), 32'(misr_model()));

      // abort at cycle 40 (entries 0..12 captured), then a random abort point
      abort_test(39);
      abort_test($urandom_range(5, 94));

      // async reset between edges at cycle 50
      for (int a = 0; a < DEPTH; a++) mtab[a] = exp_tab[a];
      randomize_ftab();
      start_pulse();
      for (int i = 0; i < 50; i++) tick();
      #2 rst = 1'b1;
      #1;
      check("arst_vec", 32'(vec), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_valid", 32'(valid), 32'd0);
      check("arst_rd_data", 32'(rd_data), 32'd0);
      check("arst_sig", 32'(sig), 32'(SIG_RST));
      @(negedge clk);
      rst = 1'b0;
      n = 50;
      for (int k = 0; k < DEPTH; k++)
         exp_tab[k] = (STEP * (k + 1) <= n) ? ftab[k] : mtab[k];
      read_all("tbl_arst");
      randomize_ftab();
      run_scan(-1, edges, busy_cnt);
      for (int a = 0; a < DEPTH; a++) begin
         exp_tab[a] = ftab[a];
         mtab[a]    = ftab[a];
      end
      check("sig_after_arst", 32'(sig), 32'(misr_model()));
      read_all("tbl_after_arst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fn_scan_ctrl.md
# fn_scan_ctrl

Sequencer that drives every input combination into the combinational logic-function unit (inputs A..E, outputs F1..F4), waits a programmable settle time, and captures the response into an internal truth-table store. A 16-bit MISR signature can also be compiled in. The block sits between the lab control registers (start/abort, readout) and the function unit. It lets a whole truth table be scanned and read back without hand-toggling inputs.

## Interface
- N_IN, 5, number of function inputs; scan covers 2^N_IN vectors
- N_OUT, 4, number of function outputs captured per vector
- SETTLE, 2, cycles the vector is held before sampling; legal range 1..15
- clk  input  1  single clock, rising-edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  begin scan; sampled only in IDLE
- abort  input  1  stop scan, return to IDLE
- vec  output  N_IN  vector driven to the function unit; vec[N_IN-1]=A … vec[0]=E
- f  input  N_OUT  function unit outputs; f[N_OUT-1]=F1 … f[0]=F4
- busy  output  1  high in DRIVE/SAMPLE
- done  output  1  one-cycle pulse on scan completion
- valid  output  1  table holds a complete scan
- rd_addr  input  N_IN  readout address
- rd_data  output  N_OUT  registered table word at rd_addr
- sig  output  16  MISR signature (see Configuration)

## Operation
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE: when start=1, load vec=0 and wait=0, clear valid, seed sig=16'hFFFF, then go to DRIVE.
- DRIVE: hold vec; wait increments by 1 each cycle. When wait==SETTLE-1, go to SAMPLE.
- SAMPLE: write f to mem[vec] and update sig.
  - If vec==2^N_IN-1, go to DONE.
  - Otherwise vec+1, wait=0, go to DRIVE.
- DONE: done=1 for this cycle; valid=1 from this cycle on; vec returns to 0. Then go to IDLE.
- abort=1 in any state other than IDLE: go to IDLE next edge with vec=0, valid=0, no done.
  - Table entries already written keep their values; later entries are stale.
  - abort has priority over SAMPLE completion on the same edge.
- start while busy, or in DONE, is ignored. start and abort together in IDLE: abort wins and the scan does not start.
- Readout: rd_data <= mem[rd_addr] every edge, one-cycle latency, in any state. Reading the address being written in SAMPLE returns the old word.
- Table is plain storage: not cleared on reset or start.
- Width rule: vec counter is N_IN bits and never wraps during a scan, because it ends at all-ones.

## Timing
- Reset values: vec=0, busy=0, done=0, valid=0, rd_data=0, sig=16'hFFFF, state IDLE, wait=0.
- Asynchronous reset mid-scan: immediate return to reset values; the table is untouched.
- Each vector takes SETTLE+1 cycles: SETTLE cycles in DRIVE, 1 in SAMPLE. f is sampled on the last edge of the SAMPLE cycle, i.e. SETTLE+1 edges after vec changed.
- start edge = E0. done is high in the cycle after edge E0 + 2^N_IN·(SETTLE+1).
  - Defaults: 96 edges; done is high in cycle 97.
- busy is high from the cycle after E0 through the last SAMPLE cycle; it is low in DONE.
- Earliest restart: start sampled one edge after done.

## Configuration
- FN_SCAN_MISR_EN defined: sig is compiled in. Each SAMPLE updates it as sig <= {sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 16'h0) ^ zero-extended f. sig holds its value in IDLE/DONE and is reseeded to 16'hFFFF on start.
- FN_SCAN_MISR_EN not defined: no MISR register; sig is tied to 16'h0000 at all times.

## Test plan
- Reset then start, with the bench modelling F2 = Σ(0,2,3,5,7,9,10,11,13,14) on vec[4:1] (A..D) and F1/F3/F4 tied 0 -> done in cycle 97. Reading rd_addr=0 gives 4'b0100; rd_addr=2 gives 4'b0000; rd_addr=4 gives 4'b0100. valid=1.
- f driven by the bench as a function of vec with a 2-cycle delay, SETTLE=2 -> every table word matches; with SETTLE=1 the bench flags the expected mismatches.
- abort asserted at cycle 40 -> IDLE on the next edge, vec=0, valid=0, no done pulse. mem[0..12] hold captured words.
- start pulsed at cycle 10 mid-scan -> ignored; done still arrives in cycle 97 after the original start.
- Async rst asserted at cycle 50 between edges -> outputs go to reset values immediately; a new start then completes normally.
- FN_SCAN_MISR_EN defined with f held 4'h0 -> sig equals the reference MISR model after 32 updates from 16'hFFFF. Without the macro -> sig=16'h0000 throughout.
